// File: rtl/pwm_generator.sv
// PWM responder: takes ratio/direction updates and applies them only at a
// period wrap, with a dead-time of zero drive before a direction reversal.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   pwm_enable       0 forces pwm_out low and holds the timebase at 0
//   pwm_update       level request to apply pwm_ratio / pwm_direction
//   pwm_ratio        high-time out of 255 (0 off, 255 always on)
//   pwm_direction    requested direction (0 CW, 1 CCW)
//   pwm_done         last request applied and nothing pending
//   pwm_out, dir_out drive pins to the motor driver
//   period_start     one-cycle pulse when the period counter wraps to 0
module pwm_generator #(
  parameter int CLK_DIV      = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out,
  output logic       period_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(DEAD_PERIODS + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] DEAD_INIT = TW'(DEAD_PERIODS);
  localparam logic [7:0]    CNT_LAST  = 8'd254;

  typedef enum logic {
    S_RUN,
    S_DEAD
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    act_ratio_q, act_ratio_d;
  logic          act_dir_q, act_dir_d;
  logic [7:0]    pnd_ratio_q, pnd_ratio_d;
  logic          pnd_dir_q, pnd_dir_d;
  logic          pending_q, pending_d;
  logic [TW-1:0] dead_q, dead_d;
  logic          pwm_out_q, pwm_out_d;
  logic          dir_out_q, dir_out_d;
  logic          ps_q, ps_d;

  logic tick;
  logic boundary;
  logic apply_ev;
  logic capture;
  logic commit;
  logic enter_dead;

  always_comb begin
    tick     = (div_q == DIV_LAST);
    boundary = pwm_enable & tick & (cnt_q == CNT_LAST);
    // A disabled PWM has no periods to wait for, so updates apply at once.
    apply_ev = boundary | ~pwm_enable;
    capture  = pwm_update & ~pending_q &
               ({pwm_direction, pwm_ratio} != {act_dir_q, act_ratio_q});

    div_d       = div_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    act_ratio_d = act_ratio_q;
    act_dir_d   = act_dir_q;
    pnd_ratio_d = pnd_ratio_q;
    pnd_dir_d   = pnd_dir_q;
    pending_d   = pending_q;
    dead_d      = dead_q;
    commit      = 1'b0;
    enter_dead  = 1'b0;

    if (!pwm_enable) begin
      div_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      div_d = '0;
      cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
    end else begin
      div_d = div_q + DW'(1);
    end

    unique case (state_q)
      S_RUN: begin
        if (pending_q && apply_ev) begin
          // Reversal from a stopped motor needs no dead-time.
          if (pnd_dir_q == act_dir_q || act_ratio_q == 8'd0)
            commit = 1'b1;
          else
            enter_dead = 1'b1;
        end
      end
      S_DEAD: begin
        if (!pwm_enable || (boundary && dead_q == TW'(1)))
          commit = 1'b1;
        else if (boundary)
          dead_d = dead_q - TW'(1);
      end
      default: state_d = S_RUN;
    endcase

    if (capture) begin
      pnd_ratio_d = pwm_ratio;
      pnd_dir_d   = pwm_direction;
      pending_d   = 1'b1;
    end
    if (commit) begin
      act_ratio_d = pnd_ratio_q;
      act_dir_d   = pnd_dir_q;
      pending_d   = 1'b0;
      state_d     = S_RUN;
    end
    if (enter_dead) begin
      act_ratio_d = 8'd0;
      dead_d      = DEAD_INIT;
      state_d     = S_DEAD;
    end

    pwm_out_d = pwm_enable & (cnt_q < act_ratio_q);
    dir_out_d = act_dir_q;
    ps_d      = boundary;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      div_q       <= '0;
      cnt_q       <= '0;
      act_ratio_q <= '0;
      act_dir_q   <= 1'b0;
      pnd_ratio_q <= '0;
      pnd_dir_q   <= 1'b0;
      pending_q   <= 1'b0;
      dead_q      <= '0;
      pwm_out_q   <= 1'b0;
      dir_out_q   <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      act_ratio_q <= act_ratio_d;
      act_dir_q   <= act_dir_d;
      pnd_ratio_q <= pnd_ratio_d;
      pnd_dir_q   <= pnd_dir_d;
      pending_q   <= pending_d;
      dead_q      <= dead_d;
      pwm_out_q   <= pwm_out_d;
      dir_out_q   <= dir_out_d;
      ps_q        <= ps_d;
    end
  end

  assign pwm_done     = ~pending_q;
  assign pwm_out      = pwm_out_q;
  assign dir_out      = dir_out_q;
  assign period_start = ps_q;

endmodule
